// File: rtl/layer_wr_ctl_if.sv
// Byte-stream input and layer write-port output bundle of the layer write controller.
// The master side feeds bytes and observes writes; the slave side is the controller.
interface layer_wr_ctl_if #(
  parameter int LAYERS     = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LANES      = 4
);
  logic                  byte_rdy_in;
  logic [7:0]            byte_data_in;
  logic                  dc_in;
  logic [LAYERS-1:0]     layer_en_out;
  logic                  frame_rdy_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic [LANES-1:0]      byte_en_out;
  logic [7:0]            byte_data_out;

  modport master (
    output byte_rdy_in, byte_data_in, dc_in,
    input  layer_en_out, frame_rdy_out, wr_addr_out, byte_en_out, byte_data_out
  );

  modport slave (
    input  byte_rdy_in, byte_data_in, dc_in,
    output layer_en_out, frame_rdy_out, wr_addr_out, byte_en_out, byte_data_out
  );
endinterface

// File: rtl/layer_wr_ctl.sv
// Command decoder between the SPI byte front end and the per-layer output stages:
// selects a layer, streams pixel bytes into lane/address writes, and signals frame end.
module layer_wr_ctl #(
  parameter int LAYERS          = 8,
  parameter int ADDR_WIDTH      = 6,
  parameter int LANES           = 4,
  parameter int BYTES_PER_PIXEL = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  layer_wr_ctl_if.slave bus
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_PIXEL - 1);

  localparam logic [7:0] CMD_LAYER_SEL = 8'h2A;
  localparam logic [7:0] CMD_DATA_WR   = 8'h2B;
  localparam logic [7:0] CMD_FRAME_END = 8'h2C;

  typedef enum logic [1:0] {
    IDLE,
    LAYER_ARG,
    DATA_WR
  } state_t;

  state_t                state_q,       state_d;
  logic [LAYERS-1:0]     layer_en_q,    layer_en_d;
  logic                  frame_rdy_q,   frame_rdy_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,     wr_addr_d;
  logic [LANES-1:0]      byte_en_q,     byte_en_d;
  logic [7:0]            byte_data_q,   byte_data_d;
  logic [LANE_W-1:0]     lane_q,        lane_d;
  logic                  inc_pending_q, inc_pending_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      layer_en_q    <= '0;
      frame_rdy_q   <= 1'b0;
      wr_addr_q     <= '0;
      byte_en_q     <= '0;
      byte_data_q   <= '0;
      lane_q        <= '0;
      inc_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_en_q    <= layer_en_d;
      frame_rdy_q   <= frame_rdy_d;
      wr_addr_q     <= wr_addr_d;
      byte_en_q     <= byte_en_d;
      byte_data_q   <= byte_data_d;
      lane_q        <= lane_d;
      inc_pending_q <= inc_pending_d;
    end
  end

  // The address step after a pixel's last lane is deferred one cycle so the
  // strobe of that lane is still presented with its own pixel address.
  always_comb begin
    state_d       = state_q;
    layer_en_d    = layer_en_q;
    frame_rdy_d   = 1'b0;
    wr_addr_d     = wr_addr_q + ADDR_WIDTH'(inc_pending_q);
    byte_en_d     = '0;
    byte_data_d   = byte_data_q;
    lane_d        = lane_q;
    inc_pending_d = 1'b0;

    if (bus.byte_rdy_in) begin
      if (!bus.dc_in) begin
        case (bus.byte_data_in)
          CMD_LAYER_SEL: state_d = LAYER_ARG;
          CMD_DATA_WR: begin
            wr_addr_d = '0;
            lane_d    = '0;
            state_d   = DATA_WR;
          end
          CMD_FRAME_END: begin
            frame_rdy_d = 1'b1;
            state_d     = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          LAYER_ARG: begin
            if ({24'd0, bus.byte_data_in} < 32'(LAYERS))
              layer_en_d = LAYERS'(1) << bus.byte_data_in;
            else
              layer_en_d = '0;
            state_d = IDLE;
          end
          DATA_WR: begin
            byte_en_d   = LANES'(1) << lane_q;
            byte_data_d = bus.byte_data_in;
            if (lane_q == LAST_LANE) begin
              lane_d        = '0;
              inc_pending_d = 1'b1;
            end else begin
              lane_d = lane_q + LANE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.layer_en_out  = layer_en_q;
  assign bus.frame_rdy_out = frame_rdy_q;
  assign bus.wr_addr_out   = wr_addr_q;
  assign bus.byte_en_out   = byte_en_q;
  assign bus.byte_data_out = byte_data_q;

endmodule

// File: tb/tb_layer_wr_ctl.sv
// Directed bench for layer_wr_ctl: inputs change on the falling edge, and the
// outputs seen at each falling edge are the response to the previous byte.
module tb_layer_wr_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  layer_wr_ctl_if #(.LAYERS(8), .ADDR_WIDTH(6), .LANES(4)) bus_if ();

  layer_wr_ctl #(
    .LAYERS(8), .ADDR_WIDTH(6), .LANES(4), .BYTES_PER_PIXEL(3)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic put(input logic dc, input logic [7:0] d);
    @(negedge clk);
    bus_if.byte_rdy_in  = 1'b1;
    bus_if.dc_in        = dc;
    bus_if.byte_data_in = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.byte_rdy_in  = 1'b0;
    bus_if.dc_in        = 1'b0;
    bus_if.byte_data_in = 8'h00;
  endtask

  task automatic test_reset();
    bus_if.byte_rdy_in  = 1'b0;
    bus_if.dc_in        = 1'b0;
    bus_if.byte_data_in = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus_if.layer_en_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_layer_en: got %h expected 00", bus_if.layer_en_out); end
    total++; if (bus_if.frame_rdy_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_rdy: got %b expected 0", bus_if.frame_rdy_out); end
    total++; if (bus_if.wr_addr_out !== 6'd0) begin bad++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", bus_if.wr_addr_out); end
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL reset_byte_en: got %b expected 0000", bus_if.byte_en_out); end
    total++; if (bus_if.byte_data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_byte_data: got %h expected 00", bus_if.byte_data_out); end
    rst = 1'b0;
  endtask

  task automatic test_layer_sel();
    put(1'b0, 8'h2A);
    put(1'b1, 8'h03);
    idle();
    total++; if (bus_if.layer_en_out !== 8'b0000_1000) begin bad++; $display("[TB] FAIL layer_sel_3: got %b expected 00001000", bus_if.layer_en_out); end
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL layer_sel_byte_en: got %b expected 0000", bus_if.byte_en_out); end
    total++; if (bus_if.frame_rdy_out !== 1'b0) begin bad++; $display("[TB] FAIL layer_sel_frame: got %b expected 0", bus_if.frame_rdy_out); end
    total++; if (bus_if.wr_addr_out !== 6'd0) begin bad++; $display("[TB] FAIL layer_sel_addr: got %0d expected 0", bus_if.wr_addr_out); end
  endtask

  task automatic test_data_wr();
    logic [3:0] exp_en   [0:6];
    logic [5:0] exp_addr [0:6];
    exp_en   = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
    exp_addr = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, 6'd2};
    put(1'b0, 8'h2B);
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) put(1'b1, 8'h10 + 8'(i));
      else idle();
      if (i == 0) begin
        total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL data_wr_cmd_no_strobe: got %b expected 0000", bus_if.byte_en_out); end
      end else begin
        total++; if (bus_if.byte_en_out !== exp_en[i-1]) begin bad++; $display("[TB] FAIL data_wr_en[%0d]: got %b expected %b", i-1, bus_if.byte_en_out, exp_en[i-1]); end
        total++; if (bus_if.wr_addr_out !== exp_addr[i-1]) begin bad++; $display("[TB] FAIL data_wr_addr[%0d]: got %0d expected %0d", i-1, bus_if.wr_addr_out, exp_addr[i-1]); end
        total++; if (bus_if.byte_data_out !== 8'h10 + 8'(i-1)) begin bad++; $display("[TB] FAIL data_wr_data[%0d]: got %h expected %h", i-1, bus_if.byte_data_out, 8'h10 + 8'(i-1)); end
      end
    end
    idle();
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL data_wr_idle_en: got %b expected 0000", bus_if.byte_en_out); end
    total++; if (bus_if.layer_en_out !== 8'b0000_1000) begin bad++; $display("[TB] FAIL data_wr_layer_hold: got %b expected 00001000", bus_if.layer_en_out); end
  endtask

  task automatic test_restart();
    put(1'b0, 8'h2B);
    for (int i = 0; i < 4; i++) put(1'b1, 8'hA0 + 8'(i));
    put(1'b0, 8'h2B);
    total++; if (bus_if.byte_en_out !== 4'b0001 || bus_if.wr_addr_out !== 6'd1) begin bad++; $display("[TB] FAIL restart_pre: got en=%b addr=%0d expected en=0001 addr=1", bus_if.byte_en_out, bus_if.wr_addr_out); end
    put(1'b1, 8'hB0);
    total++; if (bus_if.byte_en_out !== 4'b0000 || bus_if.wr_addr_out !== 6'd0) begin bad++; $display("[TB] FAIL restart_cmd: got en=%b addr=%0d expected en=0000 addr=0", bus_if.byte_en_out, bus_if.wr_addr_out); end
    idle();
    total++; if (bus_if.byte_en_out !== 4'b0001 || bus_if.wr_addr_out !== 6'd0 || bus_if.byte_data_out !== 8'hB0) begin bad++; $display("[TB] FAIL restart_first: got en=%b addr=%0d data=%h expected en=0001 addr=0 data=b0", bus_if.byte_en_out, bus_if.wr_addr_out, bus_if.byte_data_out); end
  endtask

  task automatic test_wrap();
    int k;
    put(1'b0, 8'h2B);
    for (int i = 0; i <= 195; i++) begin
      if (i < 195) put(1'b1, 8'(i));
      else idle();
      k = i - 1;
      if (k == 191) begin
        total++; if (bus_if.byte_en_out !== 4'b0100 || bus_if.wr_addr_out !== 6'd63) begin bad++; $display("[TB] FAIL wrap_last_pixel: got en=%b addr=%0d expected en=0100 addr=63", bus_if.byte_en_out, bus_if.wr_addr_out); end
      end else if (k >= 192) begin
        total++; if (bus_if.byte_en_out !== (4'b0001 << (k - 192))) begin bad++; $display("[TB] FAIL wrap_en[%0d]: got %b expected %b", k, bus_if.byte_en_out, 4'b0001 << (k - 192)); end
        total++; if (bus_if.wr_addr_out !== 6'd0) begin bad++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected 0", k, bus_if.wr_addr_out); end
        total++; if (bus_if.byte_data_out !== 8'(k)) begin bad++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", k, bus_if.byte_data_out, 8'(k)); end
      end
    end
  endtask

  task automatic test_deselect_frame();
    put(1'b0, 8'h2A);
    put(1'b1, 8'h09);
    put(1'b0, 8'h2C);
    total++; if (bus_if.layer_en_out !== 8'h00) begin bad++; $display("[TB] FAIL deselect: got %b expected 00000000", bus_if.layer_en_out); end
    total++; if (bus_if.frame_rdy_out !== 1'b0) begin bad++; $display("[TB] FAIL frame_early: got %b expected 0", bus_if.frame_rdy_out); end
    put(1'b0, 8'h2C);
    total++; if (bus_if.frame_rdy_out !== 1'b1) begin bad++; $display("[TB] FAIL frame_pulse1: got %b expected 1", bus_if.frame_rdy_out); end
    idle();
    total++; if (bus_if.frame_rdy_out !== 1'b1) begin bad++; $display("[TB] FAIL frame_pulse2: got %b expected 1", bus_if.frame_rdy_out); end
    total++; if (bus_if.layer_en_out !== 8'h00) begin bad++; $display("[TB] FAIL frame_layer_hold: got %b expected 00000000", bus_if.layer_en_out); end
    idle();
    total++; if (bus_if.frame_rdy_out !== 1'b0) begin bad++; $display("[TB] FAIL frame_end_low: got %b expected 0", bus_if.frame_rdy_out); end
  endtask

  task automatic test_ignored();
    put(1'b1, 8'hAA);
    put(1'b1, 8'hBB);
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL idle_data_ignored: got %b expected 0000", bus_if.byte_en_out); end
    put(1'b0, 8'h55);
    put(1'b1, 8'hCC);
    idle();
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL unknown_cmd_ignored: got %b expected 0000", bus_if.byte_en_out); end
    put(1'b0, 8'h2B);
    put(1'b1, 8'h01);
    put(1'b1, 8'h02);
    total++; if (bus_if.byte_en_out !== 4'b0001) begin bad++; $display("[TB] FAIL mid_lane0: got %b expected 0001", bus_if.byte_en_out); end
    put(1'b0, 8'h2C);
    total++; if (bus_if.byte_en_out !== 4'b0010) begin bad++; $display("[TB] FAIL mid_lane1: got %b expected 0010", bus_if.byte_en_out); end
    put(1'b1, 8'h03);
    total++; if (bus_if.frame_rdy_out !== 1'b1 || bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL mid_frame: got frame=%b en=%b expected frame=1 en=0000", bus_if.frame_rdy_out, bus_if.byte_en_out); end
    put(1'b1, 8'h04);
    total++; if (bus_if.frame_rdy_out !== 1'b0 || bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL after_frame_a: got frame=%b en=%b expected frame=0 en=0000", bus_if.frame_rdy_out, bus_if.byte_en_out); end
    idle();
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL after_frame_b: got %b expected 0000", bus_if.byte_en_out); end
  endtask

  task automatic test_reset_mid();
    put(1'b0, 8'h2A);
    put(1'b1, 8'h01);
    put(1'b0, 8'h2B);
    for (int i = 0; i < 17; i++) put(1'b1, 8'h40 + 8'(i));
    @(posedge clk);
    #1;
    total++; if (bus_if.byte_en_out !== 4'b0010 || bus_if.wr_addr_out !== 6'd5 || bus_if.layer_en_out !== 8'h02) begin bad++; $display("[TB] FAIL pre_reset: got en=%b addr=%0d layer=%b expected en=0010 addr=5 layer=00000010", bus_if.byte_en_out, bus_if.wr_addr_out, bus_if.layer_en_out); end
    bus_if.byte_rdy_in = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (bus_if.layer_en_out !== 8'h00) begin bad++; $display("[TB] FAIL async_layer_en: got %b expected 00000000", bus_if.layer_en_out); end
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL async_byte_en: got %b expected 0000", bus_if.byte_en_out); end
    total++; if (bus_if.wr_addr_out !== 6'd0) begin bad++; $display("[TB] FAIL async_wr_addr: got %0d expected 0", bus_if.wr_addr_out); end
    total++; if (bus_if.byte_data_out !== 8'h00) begin bad++; $display("[TB] FAIL async_byte_data: got %h expected 00", bus_if.byte_data_out); end
    total++; if (bus_if.frame_rdy_out !== 1'b0) begin bad++; $display("[TB] FAIL async_frame: got %b expected 0", bus_if.frame_rdy_out); end
    @(negedge clk);
    rst = 1'b0;
    put(1'b1, 8'h11);
    put(1'b1, 8'h22);
    total++; if (bus_if.byte_en_out !== 4'b0000) begin bad++; $display("[TB] FAIL post_reset_ignore_a: got %b expected 0000", bus_if.byte_en_out); end
    idle();
    total++; if (bus_if.byte_en_out !== 4'b0000 || bus_if.wr_addr_out !== 6'd0) begin bad++; $display("[TB] FAIL post_reset_ignore_b: got en=%b addr=%0d expected en=0000 addr=0", bus_if.byte_en_out, bus_if.wr_addr_out); end
    put(1'b0, 8'h2B);
    put(1'b1, 8'h77);
    idle();
    total++; if (bus_if.byte_en_out !== 4'b0001 || bus_if.wr_addr_out !== 6'd0 || bus_if.byte_data_out !== 8'h77) begin bad++; $display("[TB] FAIL post_reset_write: got en=%b addr=%0d data=%h expected en=0001 addr=0 data=77", bus_if.byte_en_out, bus_if.wr_addr_out, bus_if.byte_data_out); end
  endtask

  initial begin
    test_reset();
    test_layer_sel();
    test_data_wr();
    test_restart();
    test_wrap();
    test_deselect_frame();
    test_ignored();
    test_reset_mid();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
